// File: rtl/pipeline_sequencer_if.sv
// rtl/pipeline_sequencer_if.sv - control/status bundle between the pipeline datapath and its sequencer
interface pipeline_sequencer_if #(
    parameter int NB_addr = 5,
    parameter int NB_cnt  = 32
);
    logic               in_start;
    logic               in_mode_step;
    logic               in_step;
    logic               in_id_halt;
    logic [NB_addr-1:0] in_id_rs;
    logic [NB_addr-1:0] in_id_rt;
    logic               in_ex_mem_read;
    logic [NB_addr-1:0] in_ex_rt;
    logic               in_ex_branch_taken;
    logic               in_id_jump;

    logic               out_pc_en;
    logic               out_if_id_en;
    logic               out_id_ex_en;
    logic               out_ex_mem_en;
    logic               out_mem_wb_en;
    logic               out_if_id_flush;
    logic               out_id_ex_flush;
    logic [2:0]         out_state;
    logic               out_halted;
    logic [NB_cnt-1:0]  out_cycle_cnt;
    logic [NB_cnt-1:0]  out_stall_cnt;

    modport master (
        output in_start, in_mode_step, in_step, in_id_halt, in_id_rs, in_id_rt,
               in_ex_mem_read, in_ex_rt, in_ex_branch_taken, in_id_jump,
        input  out_pc_en, out_if_id_en, out_id_ex_en, out_ex_mem_en, out_mem_wb_en,
               out_if_id_flush, out_id_ex_flush, out_state, out_halted,
               out_cycle_cnt, out_stall_cnt
    );

    modport slave (
        input  in_start, in_mode_step, in_step, in_id_halt, in_id_rs, in_id_rt,
               in_ex_mem_read, in_ex_rt, in_ex_branch_taken, in_id_jump,
        output out_pc_en, out_if_id_en, out_id_ex_en, out_ex_mem_en, out_mem_wb_en,
               out_if_id_flush, out_id_ex_flush, out_state, out_halted,
               out_cycle_cnt, out_stall_cnt
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - five-stage pipeline advance/stall/flush sequencer with run, step and halt-drain
module pipeline_sequencer #(
    parameter int NB_addr = 5,
    parameter int NB_cnt  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [NB_cnt-1:0] CNT_ONE = NB_cnt'(1);

    state_t            state_q, state_d;
    logic [1:0]        drain_cnt_q, drain_cnt_d;
    logic              step_prev_q, step_prev_d;
    logic [NB_cnt-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [NB_cnt-1:0] stall_cnt_q, stall_cnt_d;

    logic [NB_addr-1:0] id_rs, id_rt, ex_rt;
    logic step_fire, adv, halt_take, load_use;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;

    assign id_rs = bus.in_id_rs;
    assign id_rt = bus.in_id_rt;
    assign ex_rt = bus.in_ex_rt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            drain_cnt_q <= 2'd0;
            step_prev_q <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            step_prev_q <= step_prev_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        step_prev_d = bus.in_step;
        stall_cnt_d = stall_cnt_q;
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;

        step_fire = bus.in_step & ~step_prev_q;
        adv       = (state_q == RUN) | ((state_q == STEP) & step_fire) | (state_q == DRAIN);
        halt_take = bus.in_id_halt;
        load_use  = bus.in_ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

        cycle_cnt_d = adv ? cycle_cnt_q + CNT_ONE : cycle_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.in_start) state_d = bus.in_mode_step ? STEP : RUN;
            end
            RUN, STEP: begin
                state_d = bus.in_mode_step ? STEP : RUN;
                if (adv) begin
                    // A taken branch discards the ID/EX contents, so halt and load-use there are wrong-path.
                    if (bus.in_ex_branch_taken) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (halt_take || load_use) begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
                        id_ex_flush = 1'b1;
                        if (halt_take) begin
                            state_d     = DRAIN;
                            drain_cnt_d = 2'd3;
                        end else begin
                            stall_cnt_d = stall_cnt_q + CNT_ONE;
                        end
                    end else begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        if_id_flush = bus.in_id_jump;
                    end
                end
            end
            DRAIN: begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
                id_ex_flush = 1'b1;
                drain_cnt_d = drain_cnt_q - 2'd1;
                if (drain_cnt_q == 2'd1) state_d = HALTED;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    assign bus.out_pc_en       = pc_en;
    assign bus.out_if_id_en    = if_id_en;
    assign bus.out_id_ex_en    = id_ex_en;
    assign bus.out_ex_mem_en   = ex_mem_en;
    assign bus.out_mem_wb_en   = mem_wb_en;
    assign bus.out_if_id_flush = if_id_flush;
    assign bus.out_id_ex_flush = id_ex_flush;
    assign bus.out_state       = state_q;
    assign bus.out_halted      = (state_q == HALTED);
    assign bus.out_cycle_cnt   = cycle_cnt_q;
    assign bus.out_stall_cnt   = stall_cnt_q;
endmodule
